// File: rtl/mem_pkg.sv
// mem_pkg: size codes, load FSM encodings and alignment helper shared by the load path.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
    return sz == SZ_RSV || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/extender.sv
// extender: widens a field to OW bits, replicating its MSB when i_signed is set.
module extender #(
  parameter int IW = 8,
  parameter int OW = 32
) (
  input  logic [IW-1:0] i_in,
  input  logic          i_signed,
  output logic [OW-1:0] o_out
);
  assign o_out = {{(OW-IW){i_signed & i_in[IW-1]}}, i_in};
endmodule

// File: rtl/load_unit.sv
// load_unit: single-outstanding memory load with lane select, extension, alignment check and ack timeout.
module load_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_data,
  output logic        o_misaligned,
  output logic        o_timeout
);
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_to;
  logic [31:0] r_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext8;
  logic [31:0] w_ext16;
  logic [31:0] w_ld;
  logic        w_last;
  assign w_byte = r_addr[1] ? (r_addr[0] ? i_mem_rdata[31:24] : i_mem_rdata[23:16])
                            : (r_addr[0] ? i_mem_rdata[15:8]  : i_mem_rdata[7:0]);
  assign w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  extender #(.IW(8),  .OW(32)) u_ext8  (.i_in(w_byte), .i_signed(r_signed), .o_out(w_ext8));
  extender #(.IW(16), .OW(32)) u_ext16 (.i_in(w_half), .i_signed(r_signed), .o_out(w_ext16));
  assign w_ld   = r_size == SZ_BYTE ? w_ext8 : r_size == SZ_HALF ? w_ext16 : i_mem_rdata;
  assign w_last = r_cnt == 8'(TIMEOUT - 1);
  assign o_mem_req    = r_state == S_REQ;
  assign o_mem_addr   = {r_addr[31:2], 2'b00};
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_state == S_DONE || r_state == S_ERR;
  assign o_data       = r_data;
  assign o_misaligned = r_state == S_ERR && !r_to;
  assign o_timeout    = r_state == S_ERR && r_to;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_to     <= 1'b0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_addr   <= i_addr;
          r_size   <= i_size;
          r_signed <= i_signed;
          r_cnt    <= '0;
          r_to     <= 1'b0;
          if (misaligned(i_addr[1:0], i_size)) begin
            r_state <= S_ERR;
            r_data  <= '0;
          end else r_state <= S_REQ;
        end
        // ack takes priority over an expiring count
        S_REQ: if (i_mem_ack) begin
          r_data  <= w_ld;
          r_state <= S_DONE;
        end else if (w_last) begin
          r_to    <= 1'b1;
          r_data  <= '0;
          r_state <= S_ERR;
        end else r_cnt <= r_cnt + 8'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: random and directed loads checked against an arithmetic load model.
module tb_load_unit;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0, ack = 1'b0;
  logic [31:0] addr = '0, rdata = '0;
  logic [1:0]  size = '0;
  logic        mem_req, busy, done, mis, tmo;
  logic [31:0] mem_addr, data;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_data = '0;

  load_unit #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_addr(addr), .i_size(size),
    .i_signed(sgn), .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(ack),
    .i_mem_rdata(rdata), .o_busy(busy), .o_done(done), .o_data(data),
    .o_misaligned(mis), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic s, input logic [31:0] d);
    int nb = 1 << sz;
    logic [31:0] mask, f;
    if (nb == 4) return d;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    f = (d >> (8 * (a % 4))) & mask;
    if (s && f[8 * nb - 1]) f = f | ~mask;
    return f;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
    return sz == 2'b11 || (a % (1 << sz)) != 0;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic s,
                         input int dly, input logic [31:0] d);
    bit acked = 0;
    addr = a; size = sz; sgn = s; start = 1'b1;
    step;
    start = 1'b0;
    if (is_mis(a, sz)) begin
      check("mis_req", mem_req, 0);
      check("mis_done", done, 1);
      check("mis_flag", mis, 1);
      check("mis_to", tmo, 0);
      check("mis_data", data, 0);
      exp_data = '0;
    end else begin
      for (int n = 0; n < TO && !acked; n++) begin
        check("req", mem_req, 1);
        check("maddr", mem_addr, {a[31:2], 2'b00});
        addr = $urandom;
        size = 2'($urandom);
        start = 1'($urandom);
        if (n == dly) begin ack = 1'b1; rdata = d; acked = 1; end
        else rdata = $urandom;
        step;
        ack = 1'b0; start = 1'b0;
      end
      check("done", done, 1);
      check("req_off", mem_req, 0);
      if (acked) begin
        exp_data = ref_load(a, sz, s, d);
        check("ok_mis", mis, 0);
        check("ok_to", tmo, 0);
        check("data", data, exp_data);
      end else begin
        exp_data = '0;
        check("to_flag", tmo, 1);
        check("to_mis", mis, 0);
        check("to_data", data, 0);
        ack = 1'b1;
        rdata = $urandom;
      end
    end
    step;
    ack = 1'b0;
    check("done_clr", done, 0);
    check("idle", busy, 0);
    check("hold", data, exp_data);
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_done", done, 0);
    check("rst_data", data, 0);
    check("rst_flags", {mis, tmo}, 0);
    step;
    rst = 1'b0;
    do_load(32'h103, 2'b00, 1'b1, 0, 32'h80AABBCC);
    do_load(32'h102, 2'b01, 1'b0, 0, 32'h80011234);
    do_load(32'h102, 2'b01, 1'b1, 0, 32'h80011234);
    do_load(32'h201, 2'b10, 1'b0, 0, 32'hDEADBEEF);
    do_load(32'h200, 2'b11, 1'b0, 0, 32'hDEADBEEF);
    do_load(32'h40, 2'b10, 1'b0, 99, 32'h0);
    do_load(32'h40, 2'b10, 1'b0, TO - 1, 32'h12345678);
    // reset during the second REQ cycle, then a late ack
    addr = 32'h104; size = 2'b10; start = 1'b1;
    step;
    start = 1'b0;
    check("rr_req1", mem_req, 1);
    step;
    check("rr_req2", mem_req, 1);
    rst = 1'b1;
    #1;
    check("rr_req_drop", mem_req, 0);
    check("rr_busy", busy, 0);
    check("rr_data", data, 0);
    ack = 1'b1; rdata = 32'hCAFEF00D;
    step;
    rst = 1'b0;
    step;
    check("rr_no_done1", done, 0);
    step;
    check("rr_no_done2", done, 0);
    ack = 1'b0;
    exp_data = '0;
    do_load(32'h104, 2'b10, 1'b0, 1, 32'hCAFEF00D);
    // start held high with zero-wait ack
    addr = 32'h10; size = 2'b10; sgn = 1'b0; start = 1'b1; ack = 1'b1; rdata = 32'h5A5AA5A5;
    for (int k = 1; k <= 12; k++) begin
      step;
      check("b2b_done", done, (k % 3) == 2);
      check("b2b_busy", busy, (k % 3) != 0);
      if (k % 3 == 2) check("b2b_data", data, 32'h5A5AA5A5);
    end
    start = 1'b0; ack = 1'b0;
    exp_data = 32'h5A5AA5A5;
    for (int i = 0; i < 80; i++)
      do_load($urandom, 2'($urandom), 1'($urandom), int'($urandom_range(0, TO)), $urandom);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles in REQ awaiting i_mem_ack before abort; legal range 2..255.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  load request, sampled only in IDLE.
REQ-005 i_addr  input  32  byte address of the load.
REQ-006 i_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 i_signed  input  1  1 sign-extension, 0 zero-extension; ignored for word.
REQ-008 o_mem_req  output  1  memory read request, held until ack or abort.
REQ-009 o_mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-010 i_mem_ack  input  1  read data valid this cycle.
REQ-011 i_mem_rdata  input  32  memory read word.
REQ-012 o_busy  output  1  high whenever state is not IDLE.
REQ-013 o_done  output  1  one-cycle completion pulse.
REQ-014 o_data  output  32  extended load result, held until the next o_done.
REQ-015 o_misaligned  output  1  valid with o_done: address/size error.
REQ-016 o_timeout  output  1  valid with o_done: no ack within TIMEOUT cycles.

Function
REQ-017 FSM states: IDLE, REQ, DONE, ERR; all outputs SHALL be registered or decoded from state only.
REQ-018 IDLE: on i_start, addr/size/signed SHALL be captured; if size==11, or size==01 with addr[0]==1, or size==10 with addr[1:0]!=0 -> ERR, else -> REQ.
REQ-019 REQ: o_mem_req=1, o_mem_addr from captured addr; ack in the first REQ cycle SHALL be accepted.
REQ-020 On ack in REQ: lane-select and extend i_mem_rdata into o_data, -> DONE; latency start-to-done SHALL be 2 cycles with zero-wait ack.
REQ-021 Lanes, little-endian: byte offset k selects rdata[8k+7:8k]; halfword offset 0 selects [15:0], offset 2 selects [31:16]; word passes [31:0].
REQ-022 Extension: upper bits SHALL equal i_signed AND selected field MSB; otherwise zero.
REQ-023 Timeout counter SHALL clear on entering REQ, increment each REQ cycle without ack; at count TIMEOUT-1 without ack -> ERR with o_timeout=1, o_mem_req deasserted next cycle.
REQ-024 Ack and timeout in the same cycle: ack SHALL win.
REQ-025 DONE: o_done=1, o_misaligned=0, o_timeout=0, -> IDLE.
REQ-026 ERR: o_done=1, exactly one of o_misaligned/o_timeout=1, o_data=0, no memory request issued for misaligned, -> IDLE.
REQ-027 i_start while o_busy=1 SHALL be ignored; i_start in IDLE the cycle after DONE SHALL be accepted.
REQ-028 i_mem_ack outside REQ SHALL be ignored.

Reset
REQ-029 i_rst SHALL force IDLE, counter 0, o_data 0, and all control outputs 0 immediately, independent of i_clk.
REQ-030 Reset mid-REQ SHALL drop o_mem_req at once; a late ack after reset SHALL produce no o_done.

Structure
REQ-031 Size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings SHALL live in shared package mem_pkg.
REQ-032 Extension SHALL reuse the existing extender module: one instance 8->32, one 16->32, selected by captured size.

Verification
REQ-033 addr 0x103, byte, signed, rdata 0x80AABBCC, ack first cycle -> o_mem_addr 0x100, o_done at cycle 2, o_data 0xFFFFFF80.
REQ-034 addr 0x102, half, unsigned, rdata 0x8001_1234 -> o_data 0x00008001; same with signed -> 0xFFFF8001.
REQ-035 addr 0x201, word -> no o_mem_req, o_done+o_misaligned next cycle, o_data 0; size 11 gives same response.
REQ-036 TIMEOUT=4, no ack -> o_mem_req high 4 cycles, then o_done+o_timeout; ack on the 4th cycle instead -> normal DONE.
REQ-037 Assert i_rst during REQ cycle 2, then ack -> o_mem_req low immediately, no o_done, next i_start serviced normally.
REQ-038 i_start held high continuously -> back-to-back loads, one per 3 cycles with zero-wait ack, starts during busy ignored.
